// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared constants and helpers for the 1-to-4 stream demultiplexer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chan_fifo.sv
// ============================================================================
// Module : chan_fifo
// Brief  : Per-channel synchronous FIFO with head-word output and occupancy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_occ
);

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic [WIDTH-1:0] r_last;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == C_FULL);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + C_ONE;
                2'b01:   r_occ <= r_occ - C_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // An empty channel keeps presenting the last word it delivered.
    assign o_head  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_occ   = r_occ;

endmodule

`default_nettype wire

// File: rtl/demux1_4_stream.sv
// ============================================================================
// Module : demux1_4_stream
// Brief  : 1-to-4 stream demultiplexer with an independent FIFO per channel.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [NUM_CH-1:0]      out_valid,
    input  logic [NUM_CH-1:0]      out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CNTW-1:0] out_cnt
);

    localparam int AW = clog2(DEPTH);

    logic               r_live;
    logic [NUM_CH-1:0]  w_push;
    logic [NUM_CH-1:0]  w_full;
    logic [NUM_CH-1:0]  w_empty;
    logic               w_accept;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_ready = r_live & ~w_full[in_sel];
    assign w_accept = in_valid & in_ready;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_chan
            logic [CNTW-1:0] r_cnt;
            logic [AW:0]     w_occ;

            assign w_push[k] = w_accept & (in_sel == SEL_W'(k));

            chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (w_push[k]),
                .i_data  (in_data),
                .i_pop   (out_ready[k]),
                .o_head  (out_data[k*WIDTH +: WIDTH]),
                .o_empty (w_empty[k]),
                .o_full  (w_full[k]),
                .o_occ   (w_occ)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_push[k]) begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end

            assign out_valid[k]              = ~w_empty[k];
            assign out_cnt[k*CNTW +: CNTW]   = r_cnt;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux1_4_stream.sv
// ============================================================================
// Module : tb_demux1_4_stream
// Brief  : Directed self-checking bench for demux1_4_stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demux1_4_stream;

    localparam int WIDTH = 2;
    localparam int DEPTH = 2;
    localparam int CNTW  = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   out_data;
    logic [31:0]  out_cnt;

    int errors;
    int checks;

    demux1_4_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 2'b00;
        in_sel    = 2'd0;
        out_ready = 4'hF;

        // Reset state
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_cnt", out_cnt, 32'h0);
        #9 rst_n = 1'b1;
        #1;
        check("pre_edge_in_ready", 32'(in_ready), 32'd0);
        step();
        check("post_edge_in_ready", 32'(in_ready), 32'd1);

        // One word per channel, all consumers ready
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 2'(k);
            step();
            check($sformatf("t1_valid_ch%0d", k), 32'(out_valid[k]), 32'd1);
            check($sformatf("t1_data_ch%0d", k), 32'(out_data[k*2 +: 2]), 32'(k));
        end
        in_valid = 1'b0;
        step();
        check("t1_valid_drained", 32'(out_valid), 32'h0);
        check("t1_data_held", 32'(out_data), 32'hE4);
        check("t1_cnt", out_cnt, 32'h01010101);

        // Fresh start for the backpressure sequence
        rst_n = 1'b0;
        #2;
        check("pulse_rst_cnt", out_cnt, 32'h0);
        rst_n = 1'b1;
        step();

        // Channel 2 stalled, three words offered
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 2'b01;
        #1;
        check("t2_ready_1", 32'(in_ready), 32'd1);
        step();
        check("t2_valid2", 32'(out_valid[2]), 32'd1);
        check("t2_head_first", 32'(out_data[5:4]), 32'h1);
        in_data = 2'b10;
        step();
        in_data = 2'b11;
        #1;
        check("t2_ready_full", 32'(in_ready), 32'd0);
        step();
        check("t2_head_held", 32'(out_data[5:4]), 32'h1);
        check("t2_cnt2", 32'(out_cnt[23:16]), 32'd2);
        check("t2_valid2_held", 32'(out_valid[2]), 32'd1);

        // No head-of-line blocking toward channel 0
        in_sel  = 2'd0;
        in_data = 2'b11;
        #1;
        check("t3_ready_ch0", 32'(in_ready), 32'd1);
        step();
        check("t3_valid0", 32'(out_valid[0]), 32'd1);
        check("t3_data0", 32'(out_data[1:0]), 32'h3);
        check("t3_cnt0", 32'(out_cnt[7:0]), 32'd1);
        in_valid = 1'b0;
        step();
        check("t3_valid0_drained", 32'(out_valid[0]), 32'd0);
        check("t3_ch2_still_full", 32'(out_valid[2]), 32'd1);

        // Channel 1: one queued word, then simultaneous push and pop
        out_ready = 4'b1001;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 2'b10;
        step();
        check("t4_head_a", 32'(out_data[3:2]), 32'h2);
        out_ready = 4'b1011;
        in_data   = 2'b01;
        #1;
        check("t4_ready", 32'(in_ready), 32'd1);
        step();
        check("t4_valid_kept", 32'(out_valid[1]), 32'd1);
        check("t4_head_b", 32'(out_data[3:2]), 32'h1);
        check("t4_cnt1", 32'(out_cnt[15:8]), 32'd2);
        in_valid = 1'b0;
        step();
        check("t4_drained", 32'(out_valid[1]), 32'd0);
        check("t4_last_held", 32'(out_data[3:2]), 32'h1);

        // in_valid low: select and data are ignored
        in_sel  = 2'd1;
        in_data = 2'b11;
        step();
        check("idle_cnt1", 32'(out_cnt[15:8]), 32'd2);
        check("idle_valid1", 32'(out_valid[1]), 32'd0);

        // 256 words to channel 3 wrap its counter
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd3;
            in_data  = 2'(i);
            step();
            if (i == 254) begin
                check("t5_cnt3_255", 32'(out_cnt[31:24]), 32'd255);
            end
        end
        in_valid = 1'b0;
        check("t5_cnt3_wrap", 32'(out_cnt[31:24]), 32'd0);
        check("t5_valid3", 32'(out_valid[3]), 32'd1);
        check("t5_data3", 32'(out_data[7:6]), 32'h3);
        step();
        check("t5_drained", 32'(out_valid[3]), 32'd0);

        // Asynchronous reset with channels 0 and 2 holding words
        out_ready = 4'b1010;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 2'b01;
        step();
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'h5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_cnt", out_cnt, 32'h0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'h0);
        #2 rst_n = 1'b1;
        out_ready = 4'hF;
        step();
        step();
        check("t6_post_valid", 32'(out_valid), 32'h0);
        check("t6_post_data", 32'(out_data), 32'h0);
        check("t6_post_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 2'b10;
        step();
        in_valid = 1'b0;
        check("t6_fresh_valid", 32'(out_valid), 32'h4);
        check("t6_fresh_data2", 32'(out_data[5:4]), 32'h2);
        check("t6_fresh_cnt", out_cnt, 32'h00010000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
